// File: rtl/sobel_filter_cfg.sv
// Streaming 3x3 Sobel edge detector with run-time frame size and selectable output mode.
// Pixel-aligned: every input pixel yields one output pixel, border pixels are forced to 0.
module sobel_filter_cfg #(
    parameter int unsigned PIXEL_W    = 8,
    parameter int unsigned MAX_WIDTH  = 1024,
    parameter int unsigned MAX_HEIGHT = 1024,
    parameter int unsigned DIM_W      = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               in_rd_en,
    input  logic               in_empty,
    input  logic [PIXEL_W-1:0] in_dout,
    output logic               out_wr_en,
    input  logic               out_full,
    output logic [PIXEL_W-1:0] out_din,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    input  logic [1:0]         cfg_mode,
    input  logic [PIXEL_W-1:0] cfg_threshold,
    output logic               busy,
    output logic               frame_done,
    output logic               cfg_error
);

    localparam int unsigned ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int unsigned G_W    = PIXEL_W + 4;
    localparam int unsigned ABS_W  = PIXEL_W + 3;
    localparam logic [PIXEL_W-1:0] PIX_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STEADY,
        FLUSH
    } state_t;

    state_t state, next_state;

    logic [DIM_W-1:0]   w_q, h_q;
    logic [1:0]         mode_q;
    logic [PIXEL_W-1:0] thr_q;
    logic [DIM_W-1:0]   x_q, y_q;
    logic [DIM_W-1:0]   ox_q, oy_q;
    logic [DIM_W-1:0]   fl_q;
    logic               rej_q;
    logic               cfg_error_q;

    // Window columns: index 0 = top row, 2 = bottom row
    logic [2:0][PIXEL_W-1:0] win_l_q, win_m_q, col_n;

    logic [PIXEL_W-1:0] lb0_mem [MAX_WIDTH];
    logic [PIXEL_W-1:0] lb1_mem [MAX_WIDTH];

    logic [ADDR_W-1:0] addr;
    logic              cfg_bad;
    logic              accept, reject;
    logic              x_last, y_last, ox_last;

    assign addr = x_q[ADDR_W-1:0];

    assign cfg_bad = (cfg_width  < DIM_W'(3)) || (cfg_width  > DIM_W'(MAX_WIDTH)) ||
                     (cfg_height < DIM_W'(3)) || (cfg_height > DIM_W'(MAX_HEIGHT));

    assign x_last  = (x_q  == w_q - DIM_W'(1));
    assign y_last  = (y_q  == h_q - DIM_W'(1));
    assign ox_last = (ox_q == w_q - DIM_W'(1));

    assign cfg_error = cfg_error_q;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and FIFO strobes
    always_comb begin
        next_state = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        frame_done = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!in_empty && !rej_q) begin
                    if (cfg_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = PRIME;
                    end
                end
            end
            PRIME: begin
                if (!in_empty) begin
                    in_rd_en = 1'b1;
                    if (y_q == DIM_W'(1) && x_q == DIM_W'(0)) begin
                        next_state = STEADY;
                    end
                end
            end
            STEADY: begin
                if (!in_empty && !out_full) begin
                    in_rd_en  = 1'b1;
                    out_wr_en = 1'b1;
                    if (x_last && y_last) begin
                        next_state = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    if (fl_q == w_q) begin
                        frame_done = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Config latch, position counters, window shift
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_q         <= '0;
            h_q         <= '0;
            mode_q      <= '0;
            thr_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            fl_q        <= '0;
            rej_q       <= 1'b0;
            cfg_error_q <= 1'b0;
            win_l_q     <= '0;
            win_m_q     <= '0;
        end else begin
            cfg_error_q <= reject;

            // A rejected config is reported once, until the request or config changes
            if (reject) begin
                rej_q <= 1'b1;
                w_q   <= cfg_width;
                h_q   <= cfg_height;
            end else if (state == IDLE &&
                         (in_empty || cfg_width != w_q || cfg_height != h_q)) begin
                rej_q <= 1'b0;
            end

            if (accept) begin
                w_q     <= cfg_width;
                h_q     <= cfg_height;
                mode_q  <= cfg_mode;
                thr_q   <= cfg_threshold;
                x_q     <= '0;
                y_q     <= '0;
                ox_q    <= '0;
                oy_q    <= '0;
                fl_q    <= '0;
                win_l_q <= '0;
                win_m_q <= '0;
            end

            if (in_rd_en) begin
                win_l_q <= win_m_q;
                win_m_q <= col_n;
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + DIM_W'(1);
                end else begin
                    x_q <= x_q + DIM_W'(1);
                end
            end

            if (out_wr_en && state == STEADY) begin
                if (ox_last) begin
                    ox_q <= '0;
                    oy_q <= oy_q + DIM_W'(1);
                end else begin
                    ox_q <= ox_q + DIM_W'(1);
                end
            end

            if (out_wr_en && state == FLUSH) begin
                fl_q <= fl_q + DIM_W'(1);
            end
        end
    end

    // Line buffers: lb0 holds row y-1, lb1 holds row y-2; read-before-write at column x
    always_ff @(posedge clock) begin
        if (in_rd_en) begin
            lb1_mem[addr] <= lb0_mem[addr];
            lb0_mem[addr] <= in_dout;
        end
    end

    assign col_n = {in_dout, lb0_mem[addr], lb1_mem[addr]};

    logic [G_W-1:0]     gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, sum, half;
    logic [ABS_W-1:0]   ax, ay;
    logic [PIXEL_W-1:0] mag, sat_x, sat_y, pix_f;
    logic               interior;

    // Gradients over the window {win_l, win_m, incoming column}; gx/gy are two's complement
    always_comb begin
        gx_pos = G_W'(col_n[0]) + (G_W'(col_n[1]) << 1) + G_W'(col_n[2]);
        gx_neg = G_W'(win_l_q[0]) + (G_W'(win_l_q[1]) << 1) + G_W'(win_l_q[2]);
        gy_pos = G_W'(win_l_q[2]) + (G_W'(win_m_q[2]) << 1) + G_W'(col_n[2]);
        gy_neg = G_W'(win_l_q[0]) + (G_W'(win_m_q[0]) << 1) + G_W'(col_n[0]);
        gx     = gx_pos - gx_neg;
        gy     = gy_pos - gy_neg;
        ax     = gx[G_W-1] ? ABS_W'(-gx) : ABS_W'(gx);
        ay     = gy[G_W-1] ? ABS_W'(-gy) : ABS_W'(gy);
        sum    = G_W'(ax) + G_W'(ay);
        half   = sum >> 1;
        mag    = (half > G_W'(PIX_MAX)) ? PIX_MAX : half[PIXEL_W-1:0];
        sat_x  = (ax > ABS_W'(PIX_MAX)) ? PIX_MAX : ax[PIXEL_W-1:0];
        sat_y  = (ay > ABS_W'(PIX_MAX)) ? PIX_MAX : ay[PIXEL_W-1:0];
    end

    // Mode select and border masking of the centre pixel
    always_comb begin
        pix_f = '0;
        case (mode_q)
            2'b00:   pix_f = mag;
            2'b01:   pix_f = sat_x;
            2'b10:   pix_f = sat_y;
            default: pix_f = (mag >= thr_q) ? PIX_MAX : '0;
        endcase
        interior = (oy_q != DIM_W'(0)) && (oy_q != h_q - DIM_W'(1)) &&
                   (ox_q != DIM_W'(0)) && !ox_last;
        out_din  = (state == STEADY && interior) ? pix_f : '0;
    end

endmodule

// File: tb/tb_sobel_filter_cfg.sv
// Randomised bench for sobel_filter_cfg: FIFO models with random stalls, compared
// against a direct convolution reference over the whole frame.
module tb_sobel_filter_cfg;

    localparam int PW   = 8;
    localparam int MAXW = 32;
    localparam int MAXH = 32;
    localparam int DW   = 6;
    localparam int PMAX = 255;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_rd_en;
    logic          in_empty;
    logic [PW-1:0] in_dout;
    logic          out_wr_en;
    logic          out_full;
    logic [PW-1:0] out_din;
    logic [DW-1:0] cfg_width;
    logic [DW-1:0] cfg_height;
    logic [1:0]    cfg_mode;
    logic [PW-1:0] cfg_threshold;
    logic          busy;
    logic          frame_done;
    logic          cfg_error;

    always #5 clock = ~clock;

    sobel_filter_cfg #(
        .PIXEL_W   (PW),
        .MAX_WIDTH (MAXW),
        .MAX_HEIGHT(MAXH),
        .DIM_W     (DW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_rd_en     (in_rd_en),
        .in_empty     (in_empty),
        .in_dout      (in_dout),
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .out_din      (out_din),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_mode     (cfg_mode),
        .cfg_threshold(cfg_threshold),
        .busy         (busy),
        .frame_done   (frame_done),
        .cfg_error    (cfg_error)
    );

    int n_checks = 0;
    int n_errors = 0;
    int in_q[$];
    int ref_img[$];
    int got_q[$];
    int saved_q[$];
    int img_b[$];
    int rd_viol, wr_viol, done_cnt;
    bit stall_en;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int px(input int w, input int r, input int c);
        return ref_img[r * w + c];
    endfunction

    // Reference Sobel: direct kernel sums on the stored image
    function automatic int ref_pix(input int w, input int h, input int mode, input int thr,
                                   input int idx);
        int r, c, gx, gy, ax, ay, m;
        r = idx / w;
        c = idx % w;
        if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return 0;
        gx = px(w, r-1, c+1) + 2 * px(w, r, c+1) + px(w, r+1, c+1)
           - px(w, r-1, c-1) - 2 * px(w, r, c-1) - px(w, r+1, c-1);
        gy = px(w, r+1, c-1) + 2 * px(w, r+1, c) + px(w, r+1, c+1)
           - px(w, r-1, c-1) - 2 * px(w, r-1, c) - px(w, r-1, c+1);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        m  = (ax + ay) / 2;
        if (m > PMAX) m = PMAX;
        case (mode)
            0:       return m;
            1:       return (ax > PMAX) ? PMAX : ax;
            2:       return (ay > PMAX) ? PMAX : ay;
            default: return (m >= thr) ? PMAX : 0;
        endcase
    endfunction

    task automatic gen_rand(input int w, input int h);
        ref_img.delete();
        for (int i = 0; i < w * h; i++) ref_img.push_back(int'($urandom_range(PMAX)));
    endtask

    // One clock: drive FIFO flags at negedge, sample strobes 1ns later
    task automatic step();
        @(negedge clock);
        in_empty = (in_q.size() == 0) || (stall_en && $urandom_range(99) < 30);
        in_dout  = (in_q.size() != 0) ? PW'(in_q[0]) : '0;
        out_full = stall_en && ($urandom_range(99) < 30);
        #1;
        if (in_rd_en && in_empty) rd_viol++;
        if (out_wr_en && out_full) wr_viol++;
        if (in_rd_en && !in_empty) void'(in_q.pop_front());
        if (out_wr_en && !out_full) got_q.push_back(int'(out_din));
        if (frame_done) done_cnt++;
    endtask

    // Runs one frame whose pixels are already in in_q; presents nw x nh for the next frame
    task automatic run_frame(input int w, input int h, input int mode, input int thr,
                             input bit stall, input int nw, input int nh);
        got_q.delete();
        rd_viol  = 0;
        wr_viol  = 0;
        done_cnt = 0;
        stall_en = stall;
        cfg_width     = DW'(w);
        cfg_height    = DW'(h);
        cfg_mode      = 2'(mode);
        cfg_threshold = PW'(thr);
        for (int i = 0; i < 4000 && done_cnt == 0; i++) step();
        check($sformatf("frame_done %0dx%0d", w, h), done_cnt, 1);
        @(negedge clock);
        in_empty   = (in_q.size() == 0);
        in_dout    = (in_q.size() != 0) ? PW'(in_q[0]) : '0;
        out_full   = 1'b0;
        cfg_width  = DW'(nw);
        cfg_height = DW'(nh);
        #1;
        check("busy_after_frame", int'(busy), 0);
        check("read_on_empty", rd_viol, 0);
        check("write_on_full", wr_viol, 0);
        check("output_count", got_q.size(), w * h);
        for (int i = 0; i < got_q.size() && i < w * h; i++)
            check($sformatf("pix[%0d] %0dx%0d m%0d", i, w, h, mode), got_q[i],
                  ref_pix(w, h, mode, thr, i));
    endtask

    task automatic reject_window(input int w, input int h);
        int errs, rds;
        errs = 0;
        rds  = 0;
        cfg_width  = DW'(w);
        cfg_height = DW'(h);
        in_empty   = 1'b0;
        in_dout    = PW'(5);
        out_full   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            #1;
            errs += int'(cfg_error);
            rds  += int'(in_rd_en);
        end
        check($sformatf("cfg_error_pulses %0dx%0d", w, h), errs, 1);
        check($sformatf("reject_no_read %0dx%0d", w, h), rds, 0);
        check("reject_idle", int'(busy), 0);
    endtask

    initial begin
        int mode_r, thr_r;
        reset_n       = 1'b0;
        in_empty      = 1'b1;
        in_dout       = '0;
        out_full      = 1'b0;
        cfg_width     = '0;
        cfg_height    = '0;
        cfg_mode      = '0;
        cfg_threshold = '0;
        stall_en      = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_rd", int'(in_rd_en), 0);
        check("rst_wr", int'(out_wr_en), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_cfg_error", int'(cfg_error), 0);
        check("rst_out_din", int'(out_din), 0);
        reset_n = 1'b1;

        // Uniform image: all outputs zero
        ref_img.delete();
        for (int i = 0; i < 48; i++) ref_img.push_back(100);
        in_q = ref_img;
        run_frame(8, 6, 0, 0, 1'b0, 8, 6);

        // Vertical step edge in every mode
        ref_img.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) ref_img.push_back((c < 2) ? 0 : 200);
        for (int m = 0; m < 4; m++) begin
            in_q = ref_img;
            run_frame(5, 5, m, 128, 1'b0, 5, 5);
            if (got_q.size() == 25) begin
                case (m)
                    0: begin
                        check("step_m0_c1", got_q[6], 255);
                        check("step_m0_c2", got_q[7], 255);
                        check("step_m0_c3", got_q[8], 0);
                    end
                    1: check("step_gx_c1", got_q[6], 255);
                    2: check("step_gy_c1", got_q[6], 0);
                    default: check("step_thr_c3", got_q[13], 0);
                endcase
            end
        end

        // Random image without and with stalls must give the same stream
        gen_rand(16, 8);
        in_q = ref_img;
        run_frame(16, 8, 0, 0, 1'b0, 16, 8);
        saved_q = got_q;
        in_q = ref_img;
        run_frame(16, 8, 0, 0, 1'b1, 16, 8);
        check("stall_len", got_q.size(), saved_q.size());
        for (int i = 0; i < got_q.size() && i < saved_q.size(); i++)
            check($sformatf("stall_eq[%0d]", i), got_q[i], saved_q[i]);

        mode_r = int'($urandom_range(3));
        thr_r  = int'($urandom_range(PMAX));
        gen_rand(7, 5);
        in_q = ref_img;
        run_frame(7, 5, mode_r, thr_r, 1'b1, 7, 5);

        // Configuration rejects, then a valid frame and a max-width frame
        reject_window(2, 4);
        reject_window(4, 2);
        reject_window(MAXW + 1, 4);
        gen_rand(4, 4);
        in_q = ref_img;
        run_frame(4, 4, 0, 0, 1'b0, 4, 4);
        gen_rand(MAXW, 3);
        in_q = ref_img;
        run_frame(MAXW, 3, 1, 0, 1'b1, MAXW, 3);
        gen_rand(6, MAXH);
        in_q = ref_img;
        run_frame(6, MAXH, 2, 0, 1'b0, 6, MAXH);

        // Reset in the middle of STEADY
        gen_rand(8, 6);
        in_q = ref_img;
        got_q.delete();
        stall_en      = 1'b0;
        cfg_width     = DW'(8);
        cfg_height    = DW'(6);
        cfg_mode      = 2'b00;
        for (int i = 0; i < 20; i++) step();
        check("steady_reached", int'(got_q.size() > 0), 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_rd", int'(in_rd_en), 0);
        check("midrst_wr", int'(out_wr_en), 0);
        check("midrst_out_din", int'(out_din), 0);
        @(negedge clock);
        #1;
        check("midrst_hold_busy", int'(busy), 0);
        reset_n = 1'b1;
        in_q.delete();
        in_empty = 1'b1;
        gen_rand(4, 4);
        in_q = ref_img;
        run_frame(4, 4, 0, 0, 1'b0, 4, 4);

        // Back-to-back frames of different width
        gen_rand(5, 3);
        img_b = ref_img;
        gen_rand(6, 4);
        in_q = ref_img;
        foreach (img_b[i]) in_q.push_back(img_b[i]);
        run_frame(6, 4, 0, 0, 1'b1, 5, 3);
        ref_img = img_b;
        run_frame(5, 3, 0, 0, 1'b1, 5, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sobel_filter_cfg.md
Name: sobel_filter_cfg

Overview:
- Next-generation streaming 3x3 Sobel edge detector for the edge_detect pipeline, sitting between the grayscale stage's output FIFO and the downstream writer FIFO.
- Generalises the fixed 8-bit, fixed-size filter. Pixel width is a parameter. Frame width and height are set per frame at run time, up to parameter maxima.
- Adds selectable output modes (magnitude, |Gx|, |Gy|, binary threshold) plus frame status signals.
- Output stream is pixel-aligned with the input stream: N pixels in produce N pixels out, and border pixels are 0.

Parameters:
- PIXEL_W, 8, bits per pixel on input and output.
- MAX_WIDTH, 1024, largest supported frame width; sets line-buffer depth.
- MAX_HEIGHT, 1024, largest supported frame height.
- DIM_W, 11, width of cfg_width, cfg_height and the internal counters; must satisfy 2^DIM_W > max(MAX_WIDTH, MAX_HEIGHT).

Ports:
- clock  in  1  single clock domain; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_rd_en  out  1  pop strobe to the input FIFO.
- in_empty  in  1  input FIFO empty.
- in_dout  in  PIXEL_W  input FIFO head data (first-word-fall-through; valid while !in_empty).
- out_wr_en  out  1  push strobe to the output FIFO.
- out_full  in  1  output FIFO full.
- out_din  out  PIXEL_W  output pixel.
- cfg_width  in  DIM_W  frame width W; sampled on IDLE exit.
- cfg_height  in  DIM_W  frame height H; sampled on IDLE exit.
- cfg_mode  in  2  00 = (|Gx|+|Gy|)>>1; 01 = |Gx|; 10 = |Gy|; 11 = threshold.
- cfg_threshold  in  PIXEL_W  threshold used by mode 11.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on the final FLUSH write.
- cfg_error  out  1  one-cycle pulse when a configuration is rejected.

Behaviour:
- Reset (reset_n low, any time, including mid-frame):
  - Outputs: all strobes, busy, frame_done, cfg_error and out_din = 0.
  - State returns to IDLE; counters and window registers clear.
  - Line-buffer contents are don't-care.
  - No partial frame is resumed.
- Strobe timing:
  - in_rd_en and out_wr_en are combinational from registered state and the current FIFO flags.
  - in_rd_en is never high while in_empty is high.
  - out_wr_en is never high while out_full is high.
- Line buffers: two internal RAM line buffers of MAX_WIDTH x PIXEL_W. Each is read and written at column index x in the same cycle (read-before-write); no FIFOs are used.

State machine:
- IDLE:
  - Waits for !in_empty, then latches cfg_*.
  - Rejects the configuration if W<3, W>MAX_WIDTH, H<3 or H>MAX_HEIGHT: cfg_error pulses, state stays IDLE, and no pixel is consumed.
  - Otherwise moves to PRIME.
- PRIME:
  - Each cycle with !in_empty: read one pixel, shift the window, update the line buffers, advance x/y.
  - No output is written.
  - After exactly W+1 pixels have been read, move to STEADY.
- STEADY:
  - Advances only when !in_empty && !out_full: read 1 pixel and write 1 pixel in the same cycle. If either side stalls, nothing moves.
  - Output for input index k is the pixel at index k-(W+1), with centre (r,c).
  - out_din = 0 if r==0, r==H-1, c==0 or c==W-1; otherwise out_din = f(window).
  - After input pixel W*H-1 is read, move to FLUSH.
- FLUSH:
  - Writes W+1 zeros, one per cycle when !out_full.
  - The last write pulses frame_done and returns to IDLE.
  - The next frame may start on the following cycle.

Arithmetic:
- Gx and Gy are signed, PIXEL_W+4 bits. Kernels: Gx = [-1 0 1; -2 0 2; -1 0 1]; Gy = [-1 -2 -1; 0 0 0; 1 2 1].
- Absolute values are PIXEL_W+3 bits unsigned.
- Mode 00 sum is PIXEL_W+4 bits, shifted right by 1 (truncate).
- Modes 00, 01 and 10 saturate to 2^PIXEL_W-1.
- Mode 11 computes the mode-00 value m, then outputs 2^PIXEL_W-1 if m >= cfg_threshold, else 0.
- Config inputs changing mid-frame have no effect until the next IDLE exit.

Test Plan:
- 8x6 frame, mode 00, PIXEL_W=8, uniform 100 -> 48 outputs, all 0; frame_done pulses once after output 48; busy low afterwards.
- 5x5 frame, columns 0-1 = 0 and columns 2-4 = 200, mode 00 -> interior centres at column 1 give (800+0)>>1 = 400, saturated to 255; centres at column 2 give 255; column 3 gives 0; all border pixels 0. Modes 01/10 on the same frame -> |Gx| = 800 saturated to 255, |Gy| = 0.
- Same 5x5 frame, mode 11, threshold 128 -> every output is 0 or 255, matching mode 00 >= 128.
- Random in_empty/out_full toggling (~30% each) on a 16x8 random image -> output stream bit-identical to the no-stall run; no read on empty; no write on full.
- cfg_width=2 and cfg_height=4 with data present -> cfg_error pulses; in_rd_en stays 0. Then cfg 4x4 -> normal frame, 16 outputs.
- reset_n asserted mid-STEADY, then deasserted, then a fresh 4x4 frame -> outputs at 0 during reset; next frame correct; two back-to-back frames of differing W run with no gap errors.
